// File: rtl/lfsr_pkg.sv
// Shared types and default parameter values for the word-oriented LFSR keystream generator.
// Imported by lfsr_word_reg and lfsr_word_gen.
package lfsr_pkg;

    localparam int unsigned DefWordW      = 4;
    localparam int unsigned DefDepth      = 16;
    localparam int unsigned DefTapA       = 2;
    localparam int unsigned DefTapB       = 3;
    localparam int unsigned DefInitRounds = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StInit,
        StRun
    } state_e;

    typedef enum logic [1:0] {
        ModeHold,
        ModeLoad,
        ModeInit,
        ModeRun
    } reg_mode_e;

    // Counter width able to hold max_val itself; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lfsr_word_reg.sv
// Word shift register with two-tap XOR feedback.
// The mode input selects hold, seed load, init step or keystream step.
module lfsr_word_reg
    import lfsr_pkg::*;
#(
    parameter int unsigned WORD_W = DefWordW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned TAP_A  = DefTapA,
    parameter int unsigned TAP_B  = DefTapB
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  reg_mode_e         mode_i,
    input  logic [WORD_W-1:0] in_data_i,
    output logic [WORD_W-1:0] out_data_o
);

    logic [WORD_W-1:0] d_q [DEPTH];
    logic [WORD_W-1:0] d_d [DEPTH];
    logic [WORD_W-1:0] fb;

    assign fb         = d_q[TAP_A] ^ d_q[TAP_B];
    assign out_data_o = d_q[DEPTH-1];

    always_comb begin
        d_d = d_q;
        unique case (mode_i)
            ModeLoad: begin
                // Seed enters at the top and walks down towards d[0].
                for (int i = 0; i < DEPTH - 1; i++) begin
                    d_d[i] = d_q[i+1];
                end
                d_d[DEPTH-1] = in_data_i;
            end
            ModeInit: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    d_d[i+1] = d_q[i];
                end
                d_d[0] = fb ^ d_q[DEPTH-1];
            end
            ModeRun: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    d_d[i+1] = d_q[i];
                end
                d_d[0] = fb;
            end
            default: begin
                d_d = d_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            d_q <= '{default: '0};
        end else begin
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/lfsr_word_gen.sv
// Keystream generator: seed load, optional mixing rounds, then one word per accepted handshake.
// Owns the control FSM and counters; the register datapath lives in lfsr_word_reg.
module lfsr_word_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned WORD_W      = DefWordW,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned TAP_A       = DefTapA,
    parameter int unsigned TAP_B       = DefTapB,
    parameter int unsigned INIT_ROUNDS = DefInitRounds
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              load_err_o
);

    localparam int unsigned LoadCntW = cnt_width(DEPTH);
    localparam int unsigned InitCntW = cnt_width(INIT_ROUNDS);
    localparam int unsigned InitLast = (INIT_ROUNDS > 0) ? INIT_ROUNDS - 1 : 0;

    state_e                state_q, state_d;
    logic [LoadCntW-1:0]   load_cnt_q, load_cnt_d;
    logic [InitCntW-1:0]   init_cnt_q, init_cnt_d;
    logic                  nz_q, nz_d;
    logic                  load_err_q, load_err_d;
    logic                  load_nz_all;
    reg_mode_e             reg_mode;

    // Non-zero tracking includes the word being accepted this cycle.
    assign load_nz_all = nz_q | (|in_data_i);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        init_cnt_d = init_cnt_q;
        nz_d       = nz_q;
        load_err_d = load_err_q;
        reg_mode   = ModeHold;
        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d    = StLoad;
                    load_cnt_d = '0;
                    nz_d       = 1'b0;
                    load_err_d = 1'b0;
                end
            end
            StLoad: begin
                if (in_valid_i) begin
                    reg_mode   = ModeLoad;
                    load_cnt_d = load_cnt_q + 1'b1;
                    nz_d       = load_nz_all;
                end
                if (stop_i) begin
                    state_d = StIdle;
                end else if (in_valid_i && (load_cnt_q == LoadCntW'(DEPTH - 1))) begin
                    if (!load_nz_all) begin
                        state_d    = StIdle;
                        load_err_d = 1'b1;
                    end else if (INIT_ROUNDS > 0) begin
                        state_d    = StInit;
                        init_cnt_d = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StInit: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else begin
                    reg_mode   = ModeInit;
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == InitCntW'(InitLast)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (out_ready_i) begin
                    reg_mode = ModeRun;
                end
                if (stop_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            init_cnt_q <= '0;
            nz_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            init_cnt_q <= init_cnt_d;
            nz_q       <= nz_d;
            load_err_q <= load_err_d;
        end
    end

    lfsr_word_reg #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .TAP_A  (TAP_A),
        .TAP_B  (TAP_B)
    ) u_reg (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .mode_i     (reg_mode),
        .in_data_i  (in_data_i),
        .out_data_o (out_data_o)
    );

    assign in_ready_o  = (state_q == StLoad);
    assign out_valid_o = (state_q == StRun);
    assign busy_o      = (state_q != StIdle);
    assign load_err_o  = load_err_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Self-checking bench: one DUT without init rounds, one with 32 init rounds.
// Expected keystream words are queued when stimulus is driven and popped on each handshake.
module tb_lfsr_word_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT a: INIT_ROUNDS = 0
    logic       a_rst_n, a_start, a_stop, a_in_valid, a_out_ready;
    logic [3:0] a_in_data;
    logic       a_in_ready, a_out_valid, a_busy, a_load_err;
    logic [3:0] a_out_data;

    // DUT b: INIT_ROUNDS = 32
    logic       b_rst_n, b_start, b_stop, b_in_valid, b_out_ready;
    logic [3:0] b_in_data;
    logic       b_in_ready, b_out_valid, b_busy, b_load_err;
    logic [3:0] b_out_data;

    lfsr_word_gen #(
        .WORD_W      (4),
        .DEPTH       (16),
        .TAP_A       (2),
        .TAP_B       (3),
        .INIT_ROUNDS (0)
    ) dut_a (
        .clk_i       (clk),
        .reset_ni    (a_rst_n),
        .start_i     (a_start),
        .stop_i      (a_stop),
        .in_data_i   (a_in_data),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .out_data_o  (a_out_data),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .busy_o      (a_busy),
        .load_err_o  (a_load_err)
    );

    lfsr_word_gen #(
        .WORD_W      (4),
        .DEPTH       (16),
        .TAP_A       (2),
        .TAP_B       (3),
        .INIT_ROUNDS (32)
    ) dut_b (
        .clk_i       (clk),
        .reset_ni    (b_rst_n),
        .start_i     (b_start),
        .stop_i      (b_stop),
        .in_data_i   (b_in_data),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .out_data_o  (b_out_data),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .busy_o      (b_busy),
        .load_err_o  (b_load_err)
    );

    logic [3:0] seed  [16] = '{4'hD, 4'hA, 4'h2, 4'h1, 4'h4, 4'h5, 4'hB, 4'hA,
                              4'h2, 4'h1, 4'hC, 4'hE, 4'h2, 4'h5, 4'h6, 4'hA};
    logic [3:0] gold  [18] = '{4'hA, 4'h6, 4'h5, 4'h2, 4'hE, 4'hC, 4'h1, 4'h2, 4'hA,
                              4'hB, 4'h5, 4'h4, 4'h1, 4'h2, 4'hA, 4'hD, 4'h3, 4'h8};
    logic [3:0] zeros [16] = '{default: 4'h0};
    logic       stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [3:0] exp_q [$];
    logic [3:0] m [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden register model
    task automatic m_load(input logic [3:0] v);
        for (int i = 0; i < 15; i++) m[i] = m[i+1];
        m[15] = v;
    endtask

    task automatic m_init_step();
        logic [3:0] f;
        f = m[2] ^ m[3] ^ m[15];
        for (int i = 15; i > 0; i--) m[i] = m[i-1];
        m[0] = f;
    endtask

    task automatic m_run_step();
        logic [3:0] f;
        f = m[2] ^ m[3];
        for (int i = 15; i > 0; i--) m[i] = m[i-1];
        m[0] = f;
    endtask

    task automatic a_begin();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_load(input logic [3:0] w [16], input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = w[i];
            tick();
        end
        a_in_valid = 1'b0;
        a_in_data  = 4'h0;
    endtask

    task automatic a_stop_pulse();
        a_out_ready = 1'b0;
        a_stop      = 1'b1;
        tick();
        a_stop      = 1'b0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_in_valid = 1'b0;
        a_in_data = 4'h0; a_out_ready = 1'b0;
        b_rst_n = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_in_valid = 1'b0;
        b_in_data = 4'h0; b_out_ready = 1'b0;
        tick();
        tick();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
        checks++; if (a_load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", a_load_err); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_run_basic();
        a_begin();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %b want 1", a_in_ready); end
        a_load(seed, 0, 16);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL run_first_valid: got %b want 1", a_out_valid); end
        foreach (gold[i]) exp_q.push_back(gold[i]);
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            a_start = (cyc == 5);  // must be ignored outside IDLE
            if (a_out_valid && a_out_ready) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                checks++;
                if (a_out_data !== e) begin
                    errors++; $display("FAIL run_word[%0d]: got %h want %h", cyc, a_out_data, e);
                end
            end
            tick();
        end
        a_start = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run_drain: %0d words left want 0", exp_q.size()); end
        exp_q.delete();
        a_stop_pulse();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL run_stop_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_stall();
        a_begin();
        a_load(seed, 0, 16);
        foreach (gold[i]) exp_q.push_back(gold[i]);
        for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
            a_out_ready = stall_pat[cyc % 4];
            if (!a_out_valid) begin
                checks++; errors++;
                $display("FAIL stall_valid[%0d]: got 0 want 1", cyc);
            end else if (a_out_ready) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                checks++;
                if (a_out_data !== e) begin
                    errors++; $display("FAIL stall_word[%0d]: got %h want %h", cyc, a_out_data, e);
                end
            end else begin
                checks++;
                if (a_out_data !== exp_q[0]) begin
                    errors++; $display("FAIL stall_hold[%0d]: got %h want %h", cyc, a_out_data, exp_q[0]);
                end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d words left want 0", exp_q.size()); end
        exp_q.delete();
        a_stop_pulse();
    endtask

    task automatic test_zero_load();
        a_begin();
        a_load(zeros, 0, 16);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", a_busy); end
        checks++; if (a_load_err !== 1'b1) begin errors++; $display("FAIL zero_load_err: got %b want 1", a_load_err); end
        repeat (3) tick();
        checks++; if (a_load_err !== 1'b1) begin errors++; $display("FAIL zero_sticky: got %b want 1", a_load_err); end
        a_begin();
        checks++; if (a_load_err !== 1'b0) begin errors++; $display("FAIL zero_clear: got %b want 0", a_load_err); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL zero_reload_ready: got %b want 1", a_in_ready); end
        a_stop_pulse();
    endtask

    task automatic test_stop_load();
        a_begin();
        a_load(seed, 0, 7);
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL stopload_busy: got %b want 0", a_busy); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stopload_in_ready: got %b want 0", a_in_ready); end
        a_begin();
        a_load(seed, 0, 15);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stopload_15_ready: got %b want 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stopload_15_valid: got %b want 0", a_out_valid); end
        a_load(seed, 15, 1);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stopload_16_valid: got %b want 1", a_out_valid); end
        checks++; if (a_out_data !== 4'hA) begin errors++; $display("FAIL stopload_first_word: got %h want a", a_out_data); end
        a_stop_pulse();
    endtask

    task automatic test_stop_priority();
        a_begin();
        a_load(seed, 0, 15);
        a_in_valid = 1'b1;
        a_in_data  = seed[15];
        a_stop     = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_stop     = 1'b0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL stopprio_busy: got %b want 0", a_busy); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stopprio_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 4'hA) begin errors++; $display("FAIL stopprio_last_hs: got %h want a", a_out_data); end
    endtask

    task automatic test_reset_run();
        a_begin();
        a_load(seed, 0, 16);
        a_out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL rstrun_pre_valid: got %b want 1", a_out_valid); end
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        a_out_ready = 1'b0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy: got %b want 0", a_busy); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstrun_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 4'h0) begin errors++; $display("FAIL rstrun_data: got %h want 0", a_out_data); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rstrun_in_ready: got %b want 0", a_in_ready); end
        a_start = 1'b1;
        a_stop  = 1'b1;
        tick();
        a_start = 1'b0;
        a_stop  = 1'b0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL startstop_busy: got %b want 0", a_busy); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL startstop_ready: got %b want 0", a_in_ready); end
    endtask

    task automatic test_init_rounds();
        int n;
        logic ready_seen;
        for (int i = 0; i < 16; i++) m[i] = 4'h0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = seed[i];
            m_load(seed[i]);
            tick();
        end
        b_in_valid = 1'b0;
        n = 0;
        ready_seen = 1'b0;
        while (!b_out_valid && n < 100) begin
            if (b_in_ready) ready_seen = 1'b1;
            n++;
            tick();
        end
        checks++; if (n != 32) begin errors++; $display("FAIL init_cycles: got %0d want 32", n); end
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL init_in_ready: got %b want 0", ready_seen); end
        repeat (32) m_init_step();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(m[15]);
            m_run_step();
        end
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            if (b_out_valid) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                checks++;
                if (b_out_data !== e) begin
                    errors++; $display("FAIL init_word[%0d]: got %h want %h", cyc, b_out_data, e);
                end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL init_drain: %0d words left want 0", exp_q.size()); end
        exp_q.delete();
        b_out_ready = 1'b0;
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_basic();
        test_stall();
        test_zero_load();
        test_stop_load();
        test_stop_priority();
        test_reset_run();
        test_init_rounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
